mult_div_unit: RTL and testbench

- Iterative multi-cycle multiply/divide responder for the single-cycle datapath's MULT/MULTU/DIV/DIVU/MFHI/MFLO instructions.
- The datapath (initiator) issues a one-cycle start request. The unit computes over a fixed latency, writes the internal HI/LO registers, and pulses done.
- The datapath stalls on busy.
- The unit complements the combinational ALU, covering operations too wide or slow for a single cycle.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mult_div_unit_negate.sv | 12 +
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 tb/tb_mult_div_unit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word width, multiply/divide opcodes and MDU control states.
package cpu_types_pkg;

  localparam int MDU_WIDTH   = 32;
  localparam int MDU_LATENCY = MDU_WIDTH + 2;

  typedef logic [MDU_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the datapath (master) and the multiply/divide unit (slave).
interface mult_div_unit_if #(
  parameter int WIDTH = cpu_types_pkg::MDU_WIDTH
);

  logic                   start;
  cpu_types_pkg::mdu_op_t op;
  logic [WIDTH-1:0]       portA;
  logic [WIDTH-1:0]       portB;
  logic                   busy;
  logic                   done;
  logic                   div_zero;
  logic [WIDTH-1:0]       hi;
  logic [WIDTH-1:0]       lo;

  modport master (
    output start, op, portA, portB,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, portA, portB,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/mult_div_unit_negate.sv
// Conditional two's-complement: used for operand magnitudes and result sign fixup.
module mdu_negate #(
  parameter int N = 64
) (
  input  logic [N-1:0] value,
  input  logic         neg,
  output logic [N-1:0] result
);

  assign result = neg ? (-value) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: fixed-latency shift-add multiply and restoring divide
// with HI/LO result registers that only change in the FIXUP cycle.
module mult_div_unit
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic            CLK,
  input  logic            nRST,
  mult_div_unit_if.slave  bus
);

  localparam int CW = $clog2(ITER + 1);

  mdu_state_t         state, state_next;
  logic [CW-1:0]      counter;
  mdu_op_t            op_q;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b, orig_a, rem_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               div_zero_q;
  logic               busy, done;

  // Operand capture: signed ops take magnitudes, unsigned ops pass through.
  logic             signed_in, neg_a_in, neg_b_in, is_div;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;

  assign signed_in = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
  assign neg_a_in  = signed_in & bus.portA[WIDTH-1];
  assign neg_b_in  = signed_in & bus.portB[WIDTH-1];
  assign is_div    = (op_q == MDU_DIV) || (op_q == MDU_DIVU);

  mdu_negate #(.N(WIDTH)) u_mag_a (.value(bus.portA), .neg(neg_a_in), .result(mag_a_in));
  mdu_negate #(.N(WIDTH)) u_mag_b (.value(bus.portB), .neg(neg_b_in), .result(mag_b_in));

  // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : '0)};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step: WIDTH+1-bit trial subtract, keep the difference if non-negative.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] rem_next, quot_next;

  assign div_shift = {rem_q, acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b};
  assign div_ok    = ~div_diff[WIDTH];
  assign rem_next  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quot_next = {acc[WIDTH-2:0], div_ok};

  // Result sign fixup; the remainder follows the dividend's sign.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  mdu_negate #(.N(2*WIDTH)) u_fix_prod (.value(acc), .neg(sign_a ^ sign_b), .result(prod_fix));
  mdu_negate #(.N(WIDTH)) u_fix_quot (.value(acc[WIDTH-1:0]), .neg(sign_a ^ sign_b), .result(quot_fix));
  mdu_negate #(.N(WIDTH)) u_fix_rem (.value(rem_q), .neg(sign_a), .result(rem_fix));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (counter == CW'(ITER - 1)) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      counter    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          counter    <= '0;
          div_zero_q <= 1'b0;
        end
        CALC: counter <= counter + CW'(1);
        FIXUP: begin
          if (is_div && (mag_b == '0)) begin
            hi_q       <= orig_a;
            lo_q       <= '1;
            div_zero_q <= 1'b1;
          end else if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: working registers are always loaded in IDLE before use, so they carry no reset.
  always_ff @(posedge CLK) begin
    case (state)
      IDLE: if (bus.start) begin
        op_q   <= bus.op;
        sign_a <= neg_a_in;
        sign_b <= neg_b_in;
        mag_a  <= mag_a_in;
        mag_b  <= mag_b_in;
        orig_a <= bus.portA;
        rem_q  <= '0;
        acc    <= {{WIDTH{1'b0}},
                   ((bus.op == MDU_DIV) || (bus.op == MDU_DIVU)) ? mag_a_in : mag_b_in};
      end
      CALC: begin
        if (is_div) begin
          acc[WIDTH-1:0] <= quot_next;
          rem_q          <= rem_next;
        end else begin
          acc <= mul_next;
        end
      end
      default: ;
    endcase
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table for results/latency plus hand-written
// sequences for start interference, start-during-done and mid-operation reset.
module tb_mult_div_unit;
  import cpu_types_pkg::*;

  localparam int ITER = MDU_WIDTH;

  typedef struct {
    mdu_op_t op;
    word_t   a;
    word_t   b;
    word_t   hi;
    word_t   lo;
    logic    dz;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mult_div_unit_if #(.WIDTH(MDU_WIDTH)) bus();

  mult_div_unit #(.WIDTH(MDU_WIDTH), .ITER(ITER)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at #1 after a rising edge with the unit idle; returns there once it is idle again.
  task automatic run_op(input mdu_op_t o, input word_t a, input word_t b,
                        output int lat, output int busy_cnt, output int done_cnt);
    bus.start = 1'b1; bus.op = o; bus.portA = a; bus.portB = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat      = -1;
    busy_cnt = bus.busy ? 1 : 0;
    done_cnt = 0;
    for (int m = 1; m <= 100; m++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (lat < 0) lat = m;
      end
      if (!bus.busy) break;
    end
  endtask

  vec_t vecs[14];

  initial begin
    int lat, bcnt, dcnt, seen_busy;

    vecs[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{MDU_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[5]  = '{MDU_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{MDU_MULTU, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0};
    vecs[7]  = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9]  = '{MDU_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{MDU_MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
    vecs[11] = '{MDU_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[12] = '{MDU_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};
    vecs[13] = '{MDU_MULTU, 32'h12345678, 32'd16,       32'h00000001, 32'h23456780, 1'b0};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = MDU_MULT; bus.portA = '0; bus.portB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset hi", bus.hi, 0);
    check("reset lo", bus.lo, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset div_zero", bus.div_zero, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, dcnt);
      check($sformatf("v%0d latency", i), lat, ITER + 1);
      check($sformatf("v%0d busy_cycles", i), bcnt, MDU_LATENCY);
      check($sformatf("v%0d done_pulses", i), dcnt, 1);
      check($sformatf("v%0d hi", i), bus.hi, vecs[i].hi);
      check($sformatf("v%0d lo", i), bus.lo, vecs[i].lo);
      check($sformatf("v%0d div_zero", i), bus.div_zero, vecs[i].dz);
    end

    // Start pulses at cycles 5 and 20 of a divide must be dropped entirely.
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.portA = 32'd100; bus.portB = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1; dcnt = 0;
    for (int m = 1; m <= 60; m++) begin
      if (m == 5 || m == 20) begin
        bus.start = 1'b1; bus.op = MDU_MULTU; bus.portA = 32'd9; bus.portB = 32'd9;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        dcnt++;
        if (lat < 0) lat = m;
      end
    end
    check("intf latency", lat, ITER + 1);
    check("intf done_pulses", dcnt, 1);
    check("intf hi", bus.hi, 32'd2);
    check("intf lo", bus.lo, 32'd14);
    check("intf busy_after", bus.busy, 0);

    // Start raised while done is high lands in DONE and is ignored.
    bus.start = 1'b1; bus.op = MDU_MULT; bus.portA = 32'hFFFFFFFD; bus.portB = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int m = 1; m <= 100; m++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = m;
        break;
      end
    end
    check("dstart done_seen", lat, ITER + 1);
    bus.start = 1'b1; bus.op = MDU_MULTU; bus.portA = 32'd9; bus.portB = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("dstart busy_next", bus.busy, 0);
    @(posedge clk); #1;
    check("dstart busy_later", bus.busy, 0);
    check("dstart lo_kept", bus.lo, 32'hFFFFFFF1);
    run_op(MDU_MULTU, 32'd9, 32'd9, lat, bcnt, dcnt);
    check("dstart retry latency", lat, ITER + 1);
    check("dstart retry lo", bus.lo, 32'd81);

    // Mid-operation reset: previous result readable while busy, then wiped asynchronously.
    run_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt, dcnt);
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.portA = 32'd100; bus.portB = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst busy_mid", bus.busy, 1);
    check("rst hi_held", bus.hi, 32'hFFFFFFFE);
    check("rst lo_held", bus.lo, 32'h00000001);
    #2 rst_n = 1'b0;
    #1;
    check("rst async hi", bus.hi, 0);
    check("rst async lo", bus.lo, 0);
    check("rst async busy", bus.busy, 0);
    check("rst async done", bus.done, 0);
    #3 rst_n = 1'b1;
    dcnt = 0; seen_busy = 0;
    for (int m = 0; m < 50; m++) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
      if (bus.busy) seen_busy++;
    end
    check("rst no_done", dcnt, 0);
    check("rst no_busy", seen_busy, 0);
    check("rst lo_after", bus.lo, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
